// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master data-memory arbiter: master index,
//   request payload struct and the default lock limit.
// Ports: none (package).
package mem_arb_pkg;

    localparam int REQ_AW       = 32;  // byte address width carried in mem_req_t
    localparam int REQ_DW       = 32;  // data width carried in mem_req_t
    localparam int BE_W         = 4;   // byte enables per data word
    localparam int MAX_LOCK_DEF = 8;   // default consecutive locked grants

    // One bit is enough: master 0 = core LSU, master 1 = debug loader.
    typedef logic mst_idx_t;

    localparam mst_idx_t MST_LSU = 1'b0;
    localparam mst_idx_t MST_DBG = 1'b1;

    // Payload a master presents alongside its request.
    typedef struct packed {
        logic              we;
        logic [REQ_AW-1:0] addr;
        logic [REQ_DW-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

    // Round-robin tie-break: the master that was not granted last wins.
    function automatic mst_idx_t rr_pick(input mst_idx_t last);
        return ~last;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter holding the last-grant pointer (and, with
//   ARB_LOCK_EN defined, the lock hold flag and consecutive-lock counter).
// Latency: grant is combinational on req and registered state (zero cycles).
// Backpressure: a loser simply sees gnt low and must keep req asserted.
// Ports: clk, rst (sync, active-high), req[1:0], lock[1:0] (ARB_LOCK_EN only),
//   gnt[1:0] one-hot or zero, gnt_idx winning master, gnt_any any grant issued.
module rr_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
`ifdef ARB_LOCK_EN
    input  logic [1:0] lock,
`endif
    output logic [1:0] gnt,
    output mst_idx_t   gnt_idx,
    output logic       gnt_any
);

    mst_idx_t last_q;   // master granted most recently
    mst_idx_t win;

`ifdef ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic          hold_q;  // previous grant was issued with its lock bit set
    logic [CW-1:0] cnt_q;   // consecutive locked grants to last_q
    logic          lock_live;

    // The lock only overrides round-robin while the owner is under its limit.
    assign lock_live = hold_q && (cnt_q < CW'(MAX_LOCK));
`endif

    always_comb begin
        win = last_q;
        case (req)
            2'b01:   win = MST_LSU;
            2'b10:   win = MST_DBG;
            2'b11:   win = rr_pick(last_q);
            default: win = last_q;
        endcase
`ifdef ARB_LOCK_EN
        if (lock_live && req[last_q]) begin
            win = last_q;
        end
`endif
    end

    // Grants are suppressed for the whole time reset is held.
    assign gnt_any = (|req) & ~rst;
    assign gnt_idx = win;
    assign gnt     = gnt_any ? ((win == MST_DBG) ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= MST_DBG;   // so master 0 wins the first tie
`ifdef ARB_LOCK_EN
            hold_q <= 1'b0;
            cnt_q  <= '0;
`endif
        end else if (gnt_any) begin
            // Pointer and lock state only move when something is granted;
            // idle cycles leave the next tie-break untouched.
            last_q <= win;
`ifdef ARB_LOCK_EN
            if (lock[win]) begin
                hold_q <= 1'b1;
                if (hold_q && (win == last_q)) begin
                    // Saturate: past the limit the owner keeps winning only
                    // when nobody else is asking.
                    if (cnt_q != CW'(MAX_LOCK)) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end else begin
                    // New owner (or freshly locked): this grant is the first.
                    cnt_q <= CW'(1);
                end
            end else begin
                hold_q <= 1'b0;
                cnt_q  <= '0;
            end
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the core LSU (master 0) and debug loader (master 1) onto one
//   single-port data memory; optional lock feature under macro ARB_LOCK_EN.
// Latency: grant same cycle as req; read response exactly one cycle later.
// Backpressure: no queuing; a losing master holds req and payload until gnt.
// Ports: i_clk, i_rst (sync, active-high); per master i_mN_req/_we/_addr/
//   _wdata/_be (+ i_mN_lock with ARB_LOCK_EN), o_mN_gnt, o_mN_rvalid,
//   o_mN_rdata; memory side o_mem_addr/_wdata/_wbe/_wren, i_mem_rdata.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = REQ_AW,
    parameter int DW       = REQ_DW,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,

    input  logic          i_m0_req,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    input  logic [3:0]    i_m0_be,
`ifdef ARB_LOCK_EN
    input  logic          i_m0_lock,
`endif
    output logic          o_m0_gnt,
    output logic          o_m0_rvalid,
    output logic [DW-1:0] o_m0_rdata,

    input  logic          i_m1_req,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    input  logic [3:0]    i_m1_be,
`ifdef ARB_LOCK_EN
    input  logic          i_m1_lock,
`endif
    output logic          o_m1_gnt,
    output logic          o_m1_rvalid,
    output logic [DW-1:0] o_m1_rdata,

    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic [3:0]    o_mem_wbe,
    output logic          o_mem_wren,
    input  logic [DW-1:0] i_mem_rdata
);

    // AW/DW are expected to match the package payload widths.
    mem_req_t   req0;
    mem_req_t   req1;
    mem_req_t   sel;

    logic [1:0] gnt;
    mst_idx_t   gnt_idx;
    logic       gnt_any;
    logic [1:0] rv_q;   // a read was granted to master N last cycle

    assign req0 = '{we: i_m0_we, addr: i_m0_addr, wdata: i_m0_wdata, be: i_m0_be};
    assign req1 = '{we: i_m1_we, addr: i_m1_addr, wdata: i_m1_wdata, be: i_m1_be};

    rr_arbiter2 #(
        .MAX_LOCK (MAX_LOCK)
    ) u_arb (
        .clk     (i_clk),
        .rst     (i_rst),
        .req     ({i_m1_req, i_m0_req}),
`ifdef ARB_LOCK_EN
        .lock    ({i_m1_lock, i_m0_lock}),
`endif
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign o_m0_gnt = gnt[0];
    assign o_m1_gnt = gnt[1];

    // Memory-side payload mux; everything is driven to zero when idle so
    // the memory never sees a stale address or stray byte enables.
    assign sel         = (gnt_idx == MST_DBG) ? req1 : req0;
    assign o_mem_addr  = gnt_any ? sel.addr  : '0;
    assign o_mem_wdata = gnt_any ? sel.wdata : '0;
    assign o_mem_wbe   = gnt_any ? sel.be    : '0;
    assign o_mem_wren  = gnt_any & sel.we;

    // The memory returns data one cycle after the address, so the response
    // route is simply the previous cycle's read grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rv_q <= 2'b00;
        end else begin
            rv_q <= gnt & {~req1.we, ~req0.we};
        end
    end

    // Masked by reset as well, so a response in flight when reset arrives
    // is dropped rather than delivered during reset.
    assign o_m0_rvalid = rv_q[0] & ~i_rst;
    assign o_m1_rvalid = rv_q[1] & ~i_rst;
    assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
    assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;

endmodule
